fir_tdm_filter: RTL and testbench

//  Multi-channel, time-multiplexed FIR filter; parametrised successor of fir_filter.

---
 rtl/fir_tdm_filter_pkg.sv | 25 ++
 rtl/fir_tdm_filter_mac_unit.sv | 77 +++++++
 rtl/fir_tdm_filter.sv | 242 ++++++++++++++++++++++++
 tb/tb_fir_tdm_filter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_tdm_filter_pkg.sv
// Shared definitions for the time-multiplexed FIR filter.
// Contents:
//   fir_state_e    - controller states (IDLE, MAC, OUT)
//   DEF_*          - default widths / sizes used by the top-level parameters
//   ch_width()     - width of a channel index, never less than one bit
package fir_tdm_filter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } fir_state_e;

  localparam int DEF_COEF_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_OUT_W  = 32;
  localparam int DEF_TAPS   = 16;
  localparam int DEF_CH     = 2;

  // A single channel still needs a 1-bit channel port.
  function automatic int ch_width(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/fir_tdm_filter_mac_unit.sv
// Single-multiplier multiply-accumulate engine of the FIR filter.
// Ports:
//   CLK, RST   clock (rising edge) / asynchronous active-high reset
//   step       perform one tap this cycle
//   first      current tap is k=0: restart the accumulator
//   coef       signed coefficient h[k]
//   sample     signed delayed sample x[n-k]
//   result     accumulator sign-extended or saturated to OUT_W
module fir_mac_unit #(
  parameter int COEF_W = 8,
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32,
  parameter int TAPS   = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     step,
  input  logic                     first,
  input  logic signed [COEF_W-1:0] coef,
  input  logic signed [DATA_W-1:0] sample,
  output logic signed [OUT_W-1:0]  result
);

  localparam int PROD_W = DATA_W + COEF_W;
  // Sum of TAPS full-scale products fits with clog2(TAPS) guard bits.
  localparam int ACC_W  = PROD_W + $clog2(TAPS);

  logic signed [PROD_W-1:0] prod_s;
  logic signed [ACC_W-1:0]  acc_base_s;
  logic signed [ACC_W-1:0]  acc_r;

  // Signed product and accumulator restart on the first tap.
  always_comb begin
    prod_s = PROD_W'(coef) * PROD_W'(sample);
    if (first) begin
      acc_base_s = '0;
    end else begin
      acc_base_s = acc_r;
    end
  end

  // Accumulator register, advances one tap per step.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_r <= '0;
    end else if (step) begin
      acc_r <= acc_base_s + ACC_W'(prod_s);
    end else begin
      acc_r <= acc_r;
    end
  end

  generate
    if (OUT_W >= ACC_W) begin : g_extend
      // Output wide enough: plain sign extension.
      always_comb begin
        result = OUT_W'(acc_r);
      end
    end else begin : g_saturate
      localparam logic signed [ACC_W-1:0] MAX_V =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      localparam logic signed [ACC_W-1:0] MIN_V =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
      // Clamp to the representable OUT_W range.
      always_comb begin
        if (acc_r > MAX_V) begin
          result = MAX_V[OUT_W-1:0];
        end else if (acc_r < MIN_V) begin
          result = MIN_V[OUT_W-1:0];
        end else begin
          result = acc_r[OUT_W-1:0];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/fir_tdm_filter.sv
// Multi-channel time-multiplexed FIR filter, one shared multiplier.
// Ports:
//   CLK, RST                clock (rising) / asynchronous active-high reset
//   ENABLE                  0 freezes controller and datapath
//   clear                   pulse: zero all delay lines (deferred while busy)
//   coef_we/addr/data       coefficient bank write, accepted only in IDLE
//   coef_err                pulse: coefficient write dropped because busy
//   in_valid/in_ready       sample handshake, in_ch selects the channel
//   input_data, sampleT     incoming sample / last accepted sample
//   out_valid, out_ch       result strobe and its channel
//   output_data             y[n] = sum h[k]*x[n-k]
module fir_tdm_filter
  import fir_tdm_filter_pkg::*;
#(
  parameter int COEF_W = DEF_COEF_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int TAPS   = DEF_TAPS,
  parameter int CH     = DEF_CH,
  localparam int AW    = $clog2(TAPS),
  localparam int CH_W  = ch_width(CH)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ENABLE,
  input  logic                     clear,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     coef_err,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_ch,
  input  logic signed [DATA_W-1:0] input_data,
  output logic signed [DATA_W-1:0] sampleT,
  output logic                     out_valid,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [OUT_W-1:0]  output_data
);

  localparam int AW1   = AW + 1;
  localparam int CH_W1 = CH_W + 1;

  fir_state_e               state_r;
  logic [AW-1:0]            k_r;
  logic [AW-1:0]            base_r;
  logic [CH_W-1:0]          ch_r;
  logic [AW-1:0]            wp_r   [CH];
  logic signed [DATA_W-1:0] dly_r  [CH][TAPS];
  logic signed [COEF_W-1:0] coef_r [TAPS];
  logic                     clear_pend_r;
  logic                     coef_err_r;
  logic                     out_valid_r;
  logic [CH_W-1:0]          out_ch_r;
  logic signed [OUT_W-1:0]  output_data_r;
  logic signed [DATA_W-1:0] sample_t_r;

  logic                     idle_s;
  logic                     clear_req_s;
  logic                     clear_apply_s;
  logic                     in_ready_s;
  logic                     accept_s;
  logic                     ch_ok_s;
  logic                     coef_ok_s;
  logic                     last_tap_s;
  logic                     mac_step_s;
  logic [AW-1:0]            rd_idx_s;
  logic signed [DATA_W-1:0] tap_x_s;
  logic signed [COEF_W-1:0] tap_h_s;
  logic signed [OUT_W-1:0]  result_s;

  // Handshake, clear arbitration and address qualification.
  always_comb begin
    idle_s        = (state_r == ST_IDLE);
    // A pending (deferred) clear blocks acceptance like a fresh one.
    clear_req_s   = clear | clear_pend_r;
    clear_apply_s = ENABLE & idle_s & clear_req_s;
    in_ready_s    = ENABLE & idle_s & ~clear_req_s;
    accept_s      = in_valid & in_ready_s;
    ch_ok_s       = ({1'b0, in_ch} < CH_W1'(CH));
    coef_ok_s     = ({1'b0, coef_addr} < AW1'(TAPS));
    last_tap_s    = (k_r == AW'(TAPS - 1));
    mac_step_s    = ENABLE & (state_r == ST_MAC);
  end

  // Circular read address: newest sample minus tap index, modulo TAPS.
  always_comb begin
    if (k_r > base_r) begin
      rd_idx_s = AW'(AW1'(base_r) + AW1'(TAPS) - AW1'(k_r));
    end else begin
      rd_idx_s = base_r - k_r;
    end
    tap_x_s = dly_r[ch_r][rd_idx_s];
    tap_h_s = coef_r[k_r];
  end

  // Controller: IDLE -> MAC (TAPS cycles) -> OUT -> IDLE, frozen when disabled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
      k_r     <= '0;
      base_r  <= '0;
      ch_r    <= '0;
    end else if (ENABLE) begin
      case (state_r)
        ST_IDLE: begin
          // Samples for a non-existent channel are swallowed without a run.
          if (accept_s && ch_ok_s) begin
            state_r <= ST_MAC;
            k_r     <= '0;
            base_r  <= wp_r[in_ch];
            ch_r    <= in_ch;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_MAC: begin
          if (last_tap_s) begin
            state_r <= ST_OUT;
            k_r     <= '0;
          end else begin
            k_r <= k_r + AW'(1);
          end
        end
        ST_OUT: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          k_r     <= '0;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  // Remembers a clear that arrived while busy or disabled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      clear_pend_r <= 1'b0;
    end else if (clear_apply_s) begin
      clear_pend_r <= 1'b0;
    end else if (clear) begin
      clear_pend_r <= 1'b1;
    end else begin
      clear_pend_r <= clear_pend_r;
    end
  end

  // Per-channel delay lines and write pointers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int c = 0; c < CH; c++) begin
        wp_r[c] <= '0;
        for (int t = 0; t < TAPS; t++) begin
          dly_r[c][t] <= '0;
        end
      end
    end else if (clear_apply_s) begin
      for (int c = 0; c < CH; c++) begin
        wp_r[c] <= '0;
        for (int t = 0; t < TAPS; t++) begin
          dly_r[c][t] <= '0;
        end
      end
    end else if (accept_s && ch_ok_s) begin
      dly_r[in_ch][wp_r[in_ch]] <= input_data;
      if (wp_r[in_ch] == AW'(TAPS - 1)) begin
        wp_r[in_ch] <= '0;
      end else begin
        wp_r[in_ch] <= wp_r[in_ch] + AW'(1);
      end
    end else begin
      wp_r <= wp_r;
    end
  end

  // Coefficient bank: writes only while idle, out-of-range addresses ignored.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int t = 0; t < TAPS; t++) begin
        coef_r[t] <= '0;
      end
      coef_err_r <= 1'b0;
    end else begin
      if (coef_we && coef_ok_s && idle_s) begin
        coef_r[coef_addr] <= coef_data;
      end else begin
        coef_r <= coef_r;
      end
      coef_err_r <= coef_we & coef_ok_s & ~idle_s;
    end
  end

  // Registered result, strobe and last-sample outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid_r   <= 1'b0;
      out_ch_r      <= '0;
      output_data_r <= '0;
      sample_t_r    <= '0;
    end else begin
      out_valid_r <= ENABLE & (state_r == ST_OUT);
      if (ENABLE && (state_r == ST_OUT)) begin
        out_ch_r      <= ch_r;
        output_data_r <= result_s;
      end else begin
        out_ch_r      <= out_ch_r;
        output_data_r <= output_data_r;
      end
      if (accept_s && ch_ok_s) begin
        sample_t_r <= input_data;
      end else begin
        sample_t_r <= sample_t_r;
      end
    end
  end

  fir_mac_unit #(
    .COEF_W (COEF_W),
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W),
    .TAPS   (TAPS)
  ) u_mac (
    .CLK    (CLK),
    .RST    (RST),
    .step   (mac_step_s),
    .first  (k_r == '0),
    .coef   (tap_h_s),
    .sample (tap_x_s),
    .result (result_s)
  );

  assign in_ready    = in_ready_s;
  assign coef_err    = coef_err_r;
  assign sampleT     = sample_t_r;
  assign out_valid   = out_valid_r;
  assign out_ch      = out_ch_r;
  assign output_data = output_data_r;

endmodule

// File: tb/tb_fir_tdm_filter.sv
// Self-checking bench for fir_tdm_filter: a shift-register FIR model feeds
// an expected-result queue; a monitor compares every out_valid strobe.
module tb_fir_tdm_filter;

  localparam int COEF_W = 8;
  localparam int DATA_W = 16;
  localparam int OUT_W  = 32;
  localparam int TAPS   = 16;
  localparam int CH     = 2;
  localparam int AW     = $clog2(TAPS);
  localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1;

  logic                     CLK = 1'b0;
  logic                     RST = 1'b1;
  logic                     ENABLE = 1'b1;
  logic                     clear = 1'b0;
  logic                     coef_we = 1'b0;
  logic [AW-1:0]            coef_addr = '0;
  logic signed [COEF_W-1:0] coef_data = '0;
  logic                     coef_err;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [CH_W-1:0]          in_ch = '0;
  logic signed [DATA_W-1:0] input_data = '0;
  logic signed [DATA_W-1:0] sampleT;
  logic                     out_valid;
  logic [CH_W-1:0]          out_ch;
  logic signed [OUT_W-1:0]  output_data;

  fir_tdm_filter #(
    .COEF_W(COEF_W), .DATA_W(DATA_W), .OUT_W(OUT_W), .TAPS(TAPS), .CH(CH)
  ) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .clear(clear),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_err(coef_err), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .input_data(input_data), .sampleT(sampleT),
    .out_valid(out_valid), .out_ch(out_ch), .output_data(output_data)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int     ch;
    longint data;
    int     cyc;
    int     dis;
  } exp_t;

  exp_t   sb_q[$];
  longint h_m [TAPS];
  longint hist[CH][TAPS];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc = 0;
  int     dis_cnt = 0;
  int     ov_cnt = 0;
  longint last_sample = 0;

  // Cycle counter and count of frozen (ENABLE low) clock edges.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (!ENABLE) dis_cnt <= dis_cnt + 1;
  end

  function automatic void check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic longint sat_out(input longint v);
    longint mx = (longint'(1) <<< (OUT_W - 1)) - 1;
    longint mn = -mx - 1;
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < CH; c++)
      for (int t = 0; t < TAPS; t++) hist[c][t] = 0;
  endfunction

  function automatic void model_reset();
    model_clear();
    for (int t = 0; t < TAPS; t++) h_m[t] = 0;
    sb_q.delete();
    last_sample = 0;
  endfunction

  // Reference: newest sample at hist[ch][0], y = sum h[k]*x[n-k].
  function automatic void model_accept(input int ch, input longint x);
    exp_t   e;
    longint acc = 0;
    for (int t = TAPS - 1; t > 0; t--) hist[ch][t] = hist[ch][t-1];
    hist[ch][0] = x;
    for (int t = 0; t < TAPS; t++) acc += h_m[t] * hist[ch][t];
    e.ch = ch; e.data = sat_out(acc); e.cyc = cyc; e.dis = dis_cnt;
    sb_q.push_back(e);
    last_sample = x;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST && out_valid) begin
        ov_cnt++;
        if (sb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_out: out_valid with data %0d, no result expected", output_data);
        end else begin
          e = sb_q.pop_front();
          check("out_data", longint'(output_data), e.data);
          check("out_ch", longint'(out_ch), longint'(e.ch));
          check("latency", longint'(cyc - e.cyc), longint'(TAPS + 2 + dis_cnt - e.dis));
        end
      end
    end
  endtask

  task automatic send(input int ch, input longint x);
    int  waitc = 0;
    bit  ok = 1'b0;
    @(posedge CLK); #1;
    in_valid = 1'b1; in_ch = CH_W'(ch); input_data = DATA_W'(x);
    while (waitc < 200) begin
      @(negedge CLK);
      if (in_ready) begin ok = 1'b1; break; end
      waitc++;
    end
    if (ok) model_accept(ch, x);
    else begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", waitc);
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
    if (ok) check("sampleT", longint'(sampleT), x);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 500) begin @(negedge CLK); n++; end
    if (sb_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d results pending, required 0", sb_q.size());
      sb_q.delete();
    end
    @(posedge CLK); #1;
  endtask

  // Only called while the filter is idle; checks no error pulse.
  task automatic write_coef(input int addr, input longint val);
    @(posedge CLK); #1;
    coef_we = 1'b1; coef_addr = AW'(addr); coef_data = COEF_W'(val);
    @(posedge CLK); #1;
    coef_we = 1'b0;
    h_m[addr] = val;
    @(negedge CLK);
    if (addr == 0) check("coef_err_idle", longint'(coef_err), 0);
  endtask

  task automatic pulse_clear();
    @(posedge CLK); #1; clear = 1'b1;
    @(posedge CLK); #1; clear = 1'b0;
    model_clear();
  endtask

  task automatic load_ramp();
    for (int t = 0; t < TAPS; t++) write_coef(t, t + 1);
  endtask

  task automatic impulse();
    send(0, 1);
    for (int i = 0; i < TAPS; i++) send(0, 0);
    drain();
  endtask

  initial begin
    int ov0;
    model_reset();
    fork
      monitor();
    join_none

    // Reset state.
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_output_data", longint'(output_data), 0);
    check("rst_sampleT", longint'(sampleT), 0);
    check("rst_coef_err", longint'(coef_err), 0);
    check("rst_out_ch", longint'(out_ch), 0);
    @(posedge CLK); #1; RST = 1'b0;
    @(negedge CLK);
    check("rst_in_ready", longint'(in_ready), 1);

    // Impulse response with h[k]=k+1.
    load_ramp();
    impulse();

    // Channel isolation: ch0 constant 100, ch1 zeros, interleaved.
    pulse_clear();
    for (int i = 0; i < TAPS; i++) begin send(0, 100); send(1, 0); end
    drain();

    // Extremes: all coefficients -128, sixteen -32768 samples on ch1.
    for (int t = 0; t < TAPS; t++) write_coef(t, -128);
    for (int i = 0; i < TAPS; i++) send(1, -32768);
    drain();
    check("extreme_out", longint'(output_data), 64'sd67108864);

    // ENABLE low for 5 cycles mid-MAC.
    load_ramp();
    send(1, 1234);
    repeat (6) @(posedge CLK);
    #1 ENABLE = 1'b0;
    repeat (5) @(posedge CLK);
    #1 ENABLE = 1'b1;
    drain();

    // Coefficient write while busy is dropped and flagged.
    send(0, 3);
    @(posedge CLK); #1;
    coef_we = 1'b1; coef_addr = AW'(3); coef_data = COEF_W'(77);
    @(posedge CLK); #1;
    coef_we = 1'b0;
    @(negedge CLK);
    check("coef_err_busy", longint'(coef_err), 1);
    @(negedge CLK);
    check("coef_err_pulse_end", longint'(coef_err), 0);
    drain();
    send(0, 5);
    drain();

    // Clear together with a request in IDLE: not accepted.
    @(posedge CLK); #1;
    clear = 1'b1; in_valid = 1'b1; in_ch = '0; input_data = DATA_W'(999);
    @(negedge CLK);
    check("clear_blocks_ready", longint'(in_ready), 0);
    @(posedge CLK); #1;
    clear = 1'b0; in_valid = 1'b0;
    model_clear();
    @(negedge CLK);
    check("clear_no_accept", longint'(sampleT), last_sample);
    check("clear_ready_back", longint'(in_ready), 1);
    send(0, 50);
    drain();

    // Clear during MAC is deferred until idle.
    send(1, 7);
    repeat (3) @(posedge CLK);
    pulse_clear();
    send(1, 9);
    drain();

    // Randomised traffic with clears, pauses and coefficient reloads.
    for (int i = 0; i < 40; i++) begin
      int ch = int'($urandom_range(CH - 1, 0));
      int xi = int'($urandom_range(65535, 0)) - 32768;
      int r  = int'($urandom_range(7, 0));
      send(ch, longint'(xi));
      if (r == 0) pulse_clear();
      else if (r == 1) begin
        repeat (int'($urandom_range(10, 0))) @(posedge CLK);
        #1 ENABLE = 1'b0;
        repeat (int'($urandom_range(6, 1))) @(posedge CLK);
        #1 ENABLE = 1'b1;
      end else if (r == 2) begin
        drain();
        write_coef(int'($urandom_range(TAPS - 1, 0)), longint'(int'($urandom_range(255, 0)) - 128));
      end
    end
    drain();

    // RST at k=7 aborts the run.
    send(0, 11);
    repeat (7) @(posedge CLK);
    #1 RST = 1'b1;
    model_reset();
    ov0 = ov_cnt;
    @(negedge CLK);
    check("abort_out_valid", longint'(out_valid), 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (TAPS + 4) @(negedge CLK);
    check("abort_no_result", longint'(ov_cnt - ov0), 0);
    check("abort_in_ready", longint'(in_ready), 1);
    check("abort_sampleT", longint'(sampleT), 0);
    load_ramp();
    impulse();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
